// File: rtl/stage_sequencer.sv
// Stage sequencer: runs up to N_STAGES handshaked processing blocks in ascending
// index order with a per-stage skip mask, single-shot/continuous modes, a
// start-to-done timeout, error capture and a wrapping pass counter.
module stage_sequencer #(
  parameter int unsigned N_STAGES  = 2,
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned SW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 continuous,
  input  logic                 go,
  input  logic [N_STAGES-1:0]  stage_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 clear_error,
  output logic [N_STAGES-1:0]  stg_start,
  output logic [N_STAGES-1:0]  stg_ack,
  input  logic [N_STAGES-1:0]  stg_done,
  input  logic [N_STAGES-1:0]  stg_error,
  output logic                 busy,
  output logic [SW-1:0]        cur_stage,
  output logic                 pass_done,
  output logic [CNT_W-1:0]     pass_count,
  output logic                 err_flag,
  output logic [SW-1:0]        err_stage,
  output logic [1:0]           err_cause
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StExec,
    StAck,
    StNext,
    StError
  } state_e;

  localparam logic [1:0] CauseStage   = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  state_e               state_q, state_d;
  logic [N_STAGES-1:0]  mask_q, mask_d;
  logic [SW-1:0]        cur_q, cur_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 ack_seen_q, ack_seen_d;
  logic [CNT_W-1:0]     pass_count_q, pass_count_d;
  logic [SW-1:0]        err_stage_q, err_stage_d;
  logic [1:0]           err_cause_q, err_cause_d;

  logic [SW-1:0]        low_idx;
  logic                 has_next;
  logic [SW-1:0]        next_idx;
  logic [N_STAGES-1:0]  cur_oh;
  logic [TIMEOUT_W-1:0] tmo_inc;

  // Lowest set bit of the live mask and the next latched stage above cur.
  always_comb begin
    low_idx  = '0;
    has_next = 1'b0;
    next_idx = '0;
    cur_oh   = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (stage_mask[i]) begin
        low_idx = SW'(i);
      end
      if (mask_q[i] && (i > int'(cur_q))) begin
        has_next = 1'b1;
        next_idx = SW'(i);
      end
    end
    for (int i = 0; i < N_STAGES; i++) begin
      cur_oh[i] = (int'(cur_q) == i);
    end
  end

  // Counter holds the number of cycles start has been high; it saturates.
  assign tmo_inc = (tmo_cnt_q == {TIMEOUT_W{1'b1}}) ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);

  // Next-state logic for the pass FSM and its bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cur_d        = cur_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack_seen_d   = ack_seen_q;
    pass_count_d = pass_count_q;
    err_stage_d  = err_stage_q;
    err_cause_d  = err_cause_q;
    unique case (state_q)
      StIdle: begin
        if (enable && (continuous || go) && (stage_mask != '0)) begin
          mask_d    = stage_mask;
          cur_d     = low_idx;
          tmo_cnt_d = TIMEOUT_W'(1);
          state_d   = StStart;
        end
      end
      StStart: begin
        tmo_cnt_d = tmo_inc;
        state_d   = StExec;
      end
      StExec: begin
        tmo_cnt_d = tmo_inc;
        if (stg_error[cur_q]) begin
          err_stage_d = cur_q;
          err_cause_d = CauseStage;
          state_d     = StError;
        end else if (stg_done[cur_q]) begin
          ack_seen_d = 1'b0;
          state_d    = StAck;
        end else if ((timeout_cycles != '0) && (tmo_cnt_q >= timeout_cycles)) begin
          err_stage_d = cur_q;
          err_cause_d = CauseTimeout;
          state_d     = StError;
        end
      end
      StAck: begin
        // Ack is held at least two cycles, and until the stage drops done.
        ack_seen_d = 1'b1;
        if (ack_seen_q && !stg_done[cur_q]) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (has_next) begin
          cur_d     = next_idx;
          tmo_cnt_d = TIMEOUT_W'(1);
          state_d   = StStart;
        end else begin
          pass_count_d = pass_count_q + CNT_W'(1);
          if (continuous && enable && (stage_mask != '0)) begin
            mask_d    = stage_mask;
            cur_d     = low_idx;
            tmo_cnt_d = TIMEOUT_W'(1);
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StError: begin
        if (clear_error) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      cur_q        <= '0;
      tmo_cnt_q    <= '0;
      ack_seen_q   <= 1'b0;
      pass_count_q <= '0;
      err_stage_q  <= '0;
      err_cause_q  <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cur_q        <= cur_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack_seen_q   <= ack_seen_d;
      pass_count_q <= pass_count_d;
      err_stage_q  <= err_stage_d;
      err_cause_q  <= err_cause_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    stg_start  = ((state_q == StStart) || (state_q == StExec)) ? cur_oh : '0;
    stg_ack    = (state_q == StAck) ? cur_oh : '0;
    busy       = (state_q == StStart) || (state_q == StExec) ||
                 (state_q == StAck) || (state_q == StNext);
    pass_done  = (state_q == StNext) && !has_next;
    err_flag   = (state_q == StError);
    cur_stage  = cur_q;
    pass_count = pass_count_q;
    err_stage  = err_stage_q;
    err_cause  = err_cause_q;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the board-level capture/min-max controller FSM.
- Runs up to N_STAGES processing blocks (camera capture, filter, bounding box, ...) in a fixed order using the start/done/ack handshake already used by the filter and photo blocks.
- Adds a per-stage skip mask, single-shot and continuous modes, a per-stage timeout, error capture and a pass counter.
- Sits in the 25 MHz pixel domain between the AHB control port and the stage blocks.

Parameters:
N_STAGES, 2, number of handshaked stages (1..16)
TIMEOUT_W, 24, width of timeout counter and timeout_cycles
CNT_W, 16, width of pass_count
(derived SW = max(1, clog2(N_STAGES)), width of stage indices)

Ports:
clk  in  1  sequencer clock
reset  in  1  synchronous, active-high reset
enable  in  1  run permission
continuous  in  1  1 = loop passes, 0 = single pass per go
go  in  1  start one pass (single-shot mode)
stage_mask  in  N_STAGES  1 = stage runs in the pass
timeout_cycles  in  TIMEOUT_W  max start-to-done cycles; 0 = no timeout
clear_error  in  1  leave ERROR state
stg_start  out  N_STAGES  start request, one-hot or zero
stg_ack  out  N_STAGES  done acknowledge, one-hot or zero
stg_done  in  N_STAGES  stage finished
stg_error  in  N_STAGES  stage fault
busy  out  1  pass in progress
cur_stage  out  SW  index of active stage
pass_done  out  1  one-cycle pulse at end of pass
pass_count  out  CNT_W  completed passes, wraps
err_flag  out  1  in ERROR state
err_stage  out  SW  stage that faulted
err_cause  out  2  01 = stage error, 10 = timeout

Behaviour:
- Reset: state IDLE. All outputs 0, including pass_count, err_stage and err_cause. Reset mid-pass has the same effect; the outputs clear on the next cycle.
- States: IDLE, START, EXEC, ACK, NEXT, ERROR. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- IDLE:
  - If enable && (continuous || go) and stage_mask != 0: latch stage_mask into mask_q, set cur_stage to the lowest set bit, go to START.
  - With a zero mask, stay in IDLE; no pass_done.
  - go is ignored outside IDLE.
- START (1 cycle): stg_start[cur] = 1, timeout counter = 1, go to EXEC.
- EXEC:
  - stg_start[cur] = 1 and the counter increments each cycle.
  - Priority: stg_error[cur] -> ERROR with cause 01; else stg_done[cur] -> ACK; else if timeout_cycles != 0 and counter == timeout_cycles -> ERROR with cause 10.
  - Done beats timeout when both occur in the same cycle.
  - stg_done and stg_error bits of non-current stages are ignored.
- ACK:
  - stg_ack[cur] = 1 and stg_start = 0.
  - Hold for at least 2 cycles and until stg_done[cur] == 0, then go to NEXT.
- NEXT (1 cycle):
  - If mask_q has a set bit above cur, set cur_stage to it and go to START.
  - Otherwise pass_done = 1 and pass_count increments (wraps to 0 at 2^CNT_W).
  - Then, if continuous && enable: relatch stage_mask; if nonzero, go to START at its lowest bit, else IDLE. If not continuous or not enabled, go to IDLE.
- busy = 1 in START, EXEC, ACK and NEXT.
- enable deasserted mid-pass: the current pass completes normally, then the block goes to IDLE.
- stage_mask changes mid-pass have no effect until the next latch.
- ERROR:
  - stg_start = stg_ack = 0, err_flag = 1. err_stage = cur and err_cause are captured on entry.
  - The block stays in ERROR until clear_error, then goes to IDLE with err_flag cleared. err_stage and err_cause are held until the next error or reset.
  - clear_error outside ERROR is ignored.
- Timeout arithmetic: the counter saturates at its maximum value and never wraps.

Test Plan:
- N=2, mask=11, continuous=0, timeout=0, stage models assert done 3 cycles after start: go pulse at cycle t -> stg_start[0] high from t+1 for 4 cycles, stg_ack[0] high 2 cycles, then stage 1 the same way -> pass_done single pulse, pass_count=1, busy=0, second go required for the next pass.
- mask=10 with go -> stg_start[0] never asserts and only stage 1 runs; mask=00 with go -> stays IDLE, busy=0, pass_count unchanged.
- timeout_cycles=5, stage 0 never done -> stg_start[0] high exactly 5 cycles, then err_flag=1, err_cause=10, err_stage=0; go ignored; clear_error -> IDLE, err_flag=0.
- Stage 1 asserts stg_error and stg_done in the same cycle -> ERROR with err_cause=01, err_stage=1, stg_ack[1] never asserts, pass_count unchanged.
- continuous=1, enable=1; drop enable during pass 3 stage 0 -> pass 3 completes, pass_count=3, returns to IDLE, no further starts.
- Assert reset during EXEC of stage 1 after 2 passes -> next cycle all stg_start and stg_ack = 0, pass_count=0, busy=0, err_flag=0.
